// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter
//   Arbiter between the three MCDF channel FIFOs and the formatter. While idle
//   it picks one eligible channel (req & en) by programmed priority, using
//   round-robin to break ties, and pulses that channel's ack for one cycle.
//   It then forwards that channel's val/data/end to the formatter, with one
//   register stage, until the packet ends. A watchdog aborts packets that run
//   too long. The packet is also aborted if the granted channel is disabled
//   while it is in flight.
//
// Ports
//   clk_i, rst_n            clock; asynchronous active-low reset
//   slvN_req_i              channel N has a packet buffered
//   slvN_val_i/_end_i       channel N word valid / last word
//   slvN_data_i [31:0]      channel N data
//   slvN_en_i               channel N enable
//   slvN_prio_i [1:0]       channel N priority (0 = highest)
//   f2a_ready_i             formatter can take a new packet (sampled only when idle)
//   a2sN_ack_o              one-cycle grant pulse to channel N
//   a2f_val_o/_data_o/_end_o  forwarded packet stream (1-cycle latency)
//   a2f_id_o [1:0]          granted channel id
//   a2f_err_o               one-cycle pulse when a packet is aborted
module mcdf_arbiter #(
  parameter int TIMEOUT = 80
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        slv0_req_i,
  input  logic        slv1_req_i,
  input  logic        slv2_req_i,
  input  logic        slv0_val_i,
  input  logic        slv1_val_i,
  input  logic        slv2_val_i,
  input  logic        slv0_end_i,
  input  logic        slv1_end_i,
  input  logic        slv2_end_i,
  input  logic [31:0] slv0_data_i,
  input  logic [31:0] slv1_data_i,
  input  logic [31:0] slv2_data_i,
  input  logic        slv0_en_i,
  input  logic        slv1_en_i,
  input  logic        slv2_en_i,
  input  logic [1:0]  slv0_prio_i,
  input  logic [1:0]  slv1_prio_i,
  input  logic [1:0]  slv2_prio_i,
  input  logic        f2a_ready_i,
  output logic        a2s0_ack_o,
  output logic        a2s1_ack_o,
  output logic        a2s2_ack_o,
  output logic        a2f_val_o,
  output logic [31:0] a2f_data_o,
  output logic [1:0]  a2f_id_o,
  output logic        a2f_end_o,
  output logic        a2f_err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       id_q, id_d;
  logic             val_q, val_d;
  logic [31:0]      data_q, data_d;
  logic             end_q, end_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] elig;
  logic [1:0] prio_a [3];
  logic [1:0] min_p;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [2:0] ack_v;
  logic       sel_val, sel_end, sel_en;
  logic [31:0] sel_data;

  // Channel visited k steps after 'last' in the cyclic order 0->1->2->0.
  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
    logic [2:0] s;
    s = {1'b0, last} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign elig      = {slv2_req_i & slv2_en_i, slv1_req_i & slv1_en_i, slv0_req_i & slv0_en_i};
  assign prio_a[0] = slv0_prio_i;
  assign prio_a[1] = slv1_prio_i;
  assign prio_a[2] = slv2_prio_i;

  // Winner: best priority value among eligible channels. Among equals, the
  // first one found after the last-granted channel wins.
  always_comb begin
    min_p = 2'd3;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (prio_a[i] < min_p)) min_p = prio_a[i];
    end
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = rr_idx(last_q, k);
      if (!found && elig[idx] && (prio_a[idx] == min_p)) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Forwarding mux, fixed to the latched channel id.
  always_comb begin
    case (id_q)
      2'd1: begin
        sel_val = slv1_val_i; sel_end = slv1_end_i; sel_data = slv1_data_i; sel_en = slv1_en_i;
      end
      2'd2: begin
        sel_val = slv2_val_i; sel_end = slv2_end_i; sel_data = slv2_data_i; sel_en = slv2_en_i;
      end
      default: begin
        sel_val = slv0_val_i; sel_end = slv0_end_i; sel_data = slv0_data_i; sel_en = slv0_en_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    val_d   = 1'b0;
    data_d  = data_q;
    end_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ack_v   = 3'b000;
    case (state_q)
      IDLE: begin
        if ((|elig) && f2a_ready_i) begin
          ack_v   = 3'b001 << win;
          id_d    = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!sel_en) begin
          // Channel disabled mid-packet: abort. The forwarded valid stays 0.
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          val_d = sel_val;
          end_d = sel_val & sel_end;
          if (sel_val) data_d = sel_data;
          // A real end takes precedence over watchdog expiry in the same cycle.
          if (sel_val && sel_end) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      id_q    <= 2'd0;
      val_q   <= 1'b0;
      data_q  <= 32'd0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      val_q   <= val_d;
      data_q  <= data_d;
      end_q   <= end_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a2s0_ack_o = ack_v[0];
  assign a2s1_ack_o = ack_v[1];
  assign a2s2_ack_o = ack_v[2];
  assign a2f_val_o  = val_q;
  assign a2f_data_o = data_q;
  assign a2f_id_o   = id_q;
  assign a2f_end_o  = end_q;
  assign a2f_err_o  = err_q;

endmodule

// File: tb/tb_mcdf_arbiter.sv
module tb_mcdf_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [2:0]  req, val, endf, en;
  logic [1:0]  prio [3];
  logic [31:0] data [3];
  logic        ready;
  logic        ack0, ack1, ack2;
  logic        a2f_val, a2f_end, a2f_err;
  logic [31:0] a2f_data;
  logic [1:0]  a2f_id;
  logic [2:0]  ack;

  assign ack = {ack2, ack1, ack0};

  mcdf_arbiter #(.TIMEOUT(80)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
    .slv0_val_i(val[0]), .slv1_val_i(val[1]), .slv2_val_i(val[2]),
    .slv0_end_i(endf[0]), .slv1_end_i(endf[1]), .slv2_end_i(endf[2]),
    .slv0_data_i(data[0]), .slv1_data_i(data[1]), .slv2_data_i(data[2]),
    .slv0_en_i(en[0]), .slv1_en_i(en[1]), .slv2_en_i(en[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .f2a_ready_i(ready),
    .a2s0_ack_o(ack0), .a2s1_ack_o(ack1), .a2s2_ack_o(ack2),
    .a2f_val_o(a2f_val), .a2f_data_o(a2f_data), .a2f_id_o(a2f_id),
    .a2f_end_o(a2f_end), .a2f_err_o(a2f_err)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int ch; logic [31:0] data; bit e; int cyc; } word_t;
  typedef struct { int ch; int cyc; } grant_t;

  word_t  exp_w[$];
  grant_t exp_ack[$];
  int     exp_err[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ack_id(input logic [2:0] a);
    return a[0] ? 0 : (a[1] ? 1 : 2);
  endfunction

  // Scoreboard monitor, mid-cycle.
  grant_t m_g;
  word_t  m_w;
  int     m_e;
  always @(negedge clk_i) begin
    if (ack != 3'b000) begin
      check_eq("ack_onehot", $countones(ack), 1);
      if (exp_ack.size() == 0) check_eq("unexpected_ack", ack, 0);
      else begin
        m_g = exp_ack.pop_front();
        check_eq("ack_ch", ack_id(ack), m_g.ch);
        check_eq("ack_cycle", cyc, m_g.cyc);
      end
    end
    if (a2f_val) begin
      if (exp_w.size() == 0) check_eq("spurious_val", a2f_val, 0);
      else begin
        m_w = exp_w.pop_front();
        check_eq("data", a2f_data, m_w.data);
        check_eq("id", a2f_id, m_w.ch);
        check_eq("end", a2f_end, m_w.e);
        check_eq("word_cycle", cyc, m_w.cyc);
      end
    end else if (a2f_end) begin
      check_eq("end_without_val", a2f_end, 0);
    end
    if (a2f_err) begin
      if (exp_err.size() == 0) check_eq("unexpected_err", a2f_err, 0);
      else begin
        m_e = exp_err.pop_front();
        check_eq("err_cycle", cyc, m_e);
      end
    end
  end

  // Expect a grant of channel ch in the current cycle, then wait for it.
  task automatic expect_grant(input int ch);
    grant_t g;
    bit seen;
    g.ch = ch;
    g.cyc = cyc;
    exp_ack.push_back(g);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (ack != 3'b000) seen = 1'b1;
    end
    check_eq("ack_seen", seen, 1);
  endtask

  // Drive a packet on channel ch starting the cycle after the ack. drop clears
  // those req bits with the first word; dis_at drops en at that word index;
  // tmo marks the packet as expected to hit the watchdog.
  task automatic send_pkt(input int ch, input int n, input bit with_end, input logic [2:0] drop,
                          input int dis_at, input bit tmo, output int last);
    word_t w;
    int i;
    bit done;
    i = 0;
    done = 1'b0;
    last = cyc;
    while (!done) begin
      @(posedge clk_i); #1;
      if (i == 0) req = req & ~drop;
      val[ch]  = 1'b1;
      data[ch] = $urandom;
      endf[ch] = with_end && (i == n - 1);
      if (i == dis_at) begin
        en[ch] = 1'b0;
        exp_err.push_back(cyc + 1);
        done = 1'b1;
      end else begin
        w.ch = ch; w.data = data[ch]; w.e = endf[ch]; w.cyc = cyc + 1;
        exp_w.push_back(w);
        if (tmo && i == n - 1) exp_err.push_back(cyc + 1);
        if (i == n - 1) done = 1'b1;
      end
      last = cyc;
      i++;
    end
    @(posedge clk_i); #1;
    val[ch]  = 1'b0;
    endf[ch] = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_val_end_err"}, {a2f_val, a2f_end, a2f_err}, 0);
    check_eq({tag, "_data_id"}, {a2f_data, a2f_id}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "tb watchdog expired");
  end

  int last;

  initial begin
    rst_n = 1'b0; req = 3'b000; val = 3'b000; endf = 3'b000; en = 3'b111; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin prio[i] = 2'd0; data[i] = 32'd0; end
    repeat (3) @(posedge clk_i); #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single channel, 4-word packet.
    @(posedge clk_i); #1;
    prio[1] = 2'd1; req[1] = 1'b1;
    expect_grant(1);
    send_pkt(1, 4, 1'b1, 3'b010, -1, 1'b0, last);
    repeat (3) @(posedge clk_i);

    // Priority: ch2 (prio 0) before ch0 (prio 2), ch0 right after the end.
    @(posedge clk_i); #1;
    prio[0] = 2'd2; prio[2] = 2'd0; req[0] = 1'b1; req[2] = 1'b1;
    expect_grant(2);
    send_pkt(2, 3, 1'b1, 3'b100, -1, 1'b0, last);
    expect_grant(0);
    send_pkt(0, 3, 1'b1, 3'b001, -1, 1'b0, last);
    repeat (2) @(posedge clk_i);

    // Reset pulse, then round-robin over six back-to-back packets.
    @(posedge clk_i); #1;
    rst_n = 1'b0; #1;
    check_outputs_zero("reset_pulse");
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) prio[i] = 2'd0;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      expect_grant(k % 3);
      send_pkt(k % 3, 2, 1'b1, 3'b000, -1, 1'b0, last);
    end

    // Backpressure: no grant while ready is low, grant in the cycle it rises.
    ready = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      check_eq("bp_no_ack", ack, 0);
    end
    @(posedge clk_i); #1;
    ready = 1'b1;
    expect_grant(0);
    send_pkt(0, 2, 1'b1, 3'b111, -1, 1'b0, last);
    repeat (2) @(posedge clk_i);

    // Watchdog: 80 words with no end, then a new grant in the err cycle.
    @(posedge clk_i); #1;
    req[2] = 1'b1;
    expect_grant(2);
    send_pkt(2, 80, 1'b0, 3'b100, -1, 1'b1, last);
    req[0] = 1'b1;
    expect_grant(0);
    send_pkt(0, 2, 1'b1, 3'b001, -1, 1'b0, last);
    repeat (2) @(posedge clk_i);

    // End on the last allowed cycle: end wins, no err.
    @(posedge clk_i); #1;
    req[1] = 1'b1;
    expect_grant(1);
    send_pkt(1, 80, 1'b1, 3'b010, -1, 1'b0, last);
    repeat (2) @(posedge clk_i);

    // Disable ch0 at its third word, then ch1 is granted normally.
    @(posedge clk_i); #1;
    req[0] = 1'b1;
    expect_grant(0);
    send_pkt(0, 5, 1'b1, 3'b001, 2, 1'b0, last);
    en[0] = 1'b1;
    req[1] = 1'b1;
    expect_grant(1);
    send_pkt(1, 2, 1'b1, 3'b010, -1, 1'b0, last);
    repeat (2) @(posedge clk_i);

    // Asynchronous reset in the middle of a packet; pointer back to 2.
    @(posedge clk_i); #1;
    req[1] = 1'b1;
    expect_grant(1);
    send_pkt(1, 2, 1'b0, 3'b010, -1, 1'b0, last);
    @(negedge clk_i); #1;
    check_eq("pre_rst_id", a2f_id, 1);
    rst_n = 1'b0; #1;
    check_outputs_zero("async_reset");
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) prio[i] = 2'd0;
    req = 3'b111;
    expect_grant(0);
    send_pkt(0, 2, 1'b1, 3'b111, -1, 1'b0, last);

    repeat (4) @(posedge clk_i);
    check_eq("words_left", exp_w.size(), 0);
    check_eq("acks_left", exp_ack.size(), 0);
    check_eq("errs_left", exp_err.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Multi-channel data formatter (MCDF) arbiter; sits directly downstream of the three per-channel slave FIFOs.
- Selects one requesting channel by register-programmed priority, with round-robin tie-break.
- Issues a single-cycle ack to the selected FIFO, then forwards that channel's packet (data/valid/end) to the formatter.
- Exactly one packet is in flight at a time; a watchdog detects packets that never end.

Parameters:
TIMEOUT, 'd80, XFER cycles allowed without slvx_end before abort (must exceed max packet length + 2)

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  channel has at least one packet buffered
slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  channel data valid
slv0_end_i / slv1_end_i / slv2_end_i  in  1 each  channel last word of packet
slv0_data_i / slv1_data_i / slv2_data_i  in  32 each  channel data
slv0_en_i / slv1_en_i / slv2_en_i  in  1 each  channel enable (register)
slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  priority; 0 = highest
f2a_ready_i  in  1  formatter can accept a new packet
a2s0_ack_o / a2s1_ack_o / a2s2_ack_o  out  1 each  one-cycle grant pulse to channel FIFO
a2f_val_o  out  1  forwarded valid
a2f_data_o  out  32  forwarded data
a2f_id_o  out  2  granted channel id (0..2)
a2f_end_o  out  1  forwarded last-word flag
a2f_err_o  out  1  one-cycle pulse on aborted packet

Behaviour:
- Reset: state IDLE; all outputs 0; last-granted pointer = 2, so channel 0 wins the first tie.
- Eligible channel: req & en.
- Winner = lowest prio value among eligible channels. Ties go to the first eligible channel after the last-granted one, in order 0->1->2->0.
- FSM IDLE:
  - Stays IDLE if no eligible channel or f2a_ready_i=0.
  - Otherwise latches winner into a2f_id_o and the last-granted pointer, drives that channel's ack=1 for exactly this cycle, and goes to XFER.
  - Selection is combinational on the current-cycle inputs.
- FSM XFER:
  - Mux is fixed to the latched id; inputs from the other channels are ignored.
  - a2f_val_o / a2f_data_o / a2f_end_o are registered copies of the selected channel's val/data/end: exactly 1 cycle latency, no bubbles inserted, and data is held when val=0.
  - When the selected val & end are sampled high, go to IDLE. The forwarded end pulse appears on the following cycle.
  - The earliest next ack is therefore in the cycle after the end is sampled, so consecutive grants are at least pkglen+1 cycles apart.
- Watchdog:
  - Counter cleared on entering XFER; increments each XFER cycle.
  - On reaching TIMEOUT-1 with no end: return to IDLE and pulse a2f_err_o for 1 cycle. No a2f_end_o is generated.
- Mid-packet disable: if the granted channel's en drops during XFER, abort next cycle to IDLE with a2f_err_o pulse and a2f_val_o forced 0. A partial packet remains at the formatter; discarding it is the formatter's job.
- Acks: never more than one ack high; an ack is never issued while in XFER.
- f2a_ready_i is sampled only in IDLE. Dropping it during XFER has no effect.
- Simultaneous end and timeout-expiry in the same cycle: end wins, no err.
- Asynchronous reset mid-XFER: immediate return to the reset values; the pointer returns to 2.

Test Plan:
- Single channel: ch1 req=1, prio=1, others idle, pkglen=4; ch1 val high cycles T+1..T+4, end at T+4 -> a2s1_ack_o high only at T; a2f_val_o high T+2..T+5; a2f_end_o at T+5; a2f_id_o=1.
- Priority: ch0 prio=2, ch2 prio=0, both req -> ch2 granted first; after its end, ch0 granted on the next eligible cycle.
- Round-robin: all prio=0, all req held high -> grant order 0,1,2,0,1,2 across 6 packets; no ack overlaps.
- Backpressure: all req=1, f2a_ready_i=0 for 10 cycles -> no ack. ready=1 -> ack in that same cycle.
- Timeout: TIMEOUT=80, granted channel never asserts end -> after 80 XFER cycles a2f_err_o pulses once, FSM back to IDLE, new grant possible next cycle.
- Disable mid-packet: slv0_en_i dropped at the 3rd word -> a2f_err_o pulses, a2f_val_o=0 from the next cycle, no a2f_end_o; a later request from ch1 is granted normally.
